jt900h_intctl: RTL

//  Interrupt controller that drives the 3-bit intrq level input of the jt900h CPU.

---
 rtl/jt900h_intctl_pkg.sv | 35 +++
 rtl/jt900h_intctl_arb.sv | 24 ++
 rtl/jt900h_intctl.sv | 103 ++++++++++
 3 files changed

// File: rtl/jt900h_intctl_pkg.sv
// Shared definitions for the jt900h interrupt controller: register word
// offsets, the register-select type and the bus address decoder.
package jt900h_intctl_pkg;

    // Word offsets (in 16-bit words) from the base of the register window
    localparam logic [22:0] REG_PEND = 23'd0;
    localparam logic [22:0] REG_MODE = 23'd1;
    localparam logic [22:0] REG_PRIA = 23'd2;
    localparam logic [22:0] REG_PRIB = 23'd3;
    localparam logic [22:0] REG_VEC  = 23'd4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PEND,
        SEL_MODE,
        SEL_PRIA,
        SEL_PRIB,
        SEL_VEC
    } reg_sel_e;

    // addr[0] is ignored: the window is matched on word addresses only
    function automatic reg_sel_e decode(input logic [23:0] addr, input logic [23:0] base);
        logic [22:0] off;
        off = addr[23:1] - base[23:1];
        case (off)
            REG_PEND: decode = SEL_PEND;
            REG_MODE: decode = SEL_MODE;
            REG_PRIA: decode = SEL_PRIA;
            REG_PRIB: decode = SEL_PRIB;
            REG_VEC:  decode = SEL_VEC;
            default:  decode = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/jt900h_intctl_arb.sv
// Combinational priority encoder: picks the pending source with the largest
// nonzero priority; ties resolve to the lowest source index.
module jt900h_intctl_arb
    import jt900h_intctl_pkg::*;
(
    input  logic [7:0]  pending,
    input  logic [23:0] pri,
    output logic [2:0]  level,
    output logic [2:0]  index
);

    // Strict '>' keeps the earliest (lowest index) source on equal priority
    always_comb begin
        level = 3'd0;
        index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i] && (pri[i*3 +: 3] > level)) begin
                level = pri[i*3 +: 3];
                index = 3'(i);
            end
        end
    end

endmodule

// File: rtl/jt900h_intctl.sv
// Memory-mapped interrupt controller driving the jt900h intrq level input.
// Synchronises raw requests, latches them as pending (edge or level mode),
// and presents the highest programmed priority with its source index.
module jt900h_intctl
    import jt900h_intctl_pkg::*;
#(
    parameter int          NSRC = 8,
    parameter logic [23:0] BASE = 24'hFF00
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [23:0]     addr,
    input  logic [15:0]     wdata,
    input  logic [1:0]      we,
    output logic [15:0]     rdata,
    input  logic [NSRC-1:0] src,
    output logic [2:0]      intrq,
    output logic [2:0]      vector
);

    localparam logic [7:0] SRC_MASK = 8'((1 << NSRC) - 1);

    logic [7:0]      src_w;
    logic [7:0]      s1_p0, s2_p1, s2d_p2;
    logic [7:0]      pend, mode;
    logic [7:0][2:0] pri;
    logic [7:0]      pend_set, pend_clr;
    logic [2:0]      win_level, win_index;
    logic [15:0]     rd_val;
    reg_sel_e        sel;

    assign src_w = 8'(src);
    assign sel   = decode(addr, BASE);

    // Two-flop synchroniser runs on every clock, independent of cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p0 <= '0;
            s2_p1 <= '0;
        end else begin
            s1_p0 <= src_w;
            s2_p1 <= s1_p0;
        end
    end

    // Set/clear terms for the pending latch; set always wins over a clear
    always_comb begin
        pend_set = SRC_MASK & ((mode & s2_p1 & ~s2d_p2) | (~mode & s2_p1));
        pend_clr = '0;
        if (sel == SEL_PEND && we[0])
            pend_clr = wdata[7:0];
    end

    // Read mux: unimplemented sources and unmapped words return zero
    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_PEND: rd_val = {8'd0, pend};
            SEL_MODE: rd_val = {8'd0, mode};
            SEL_PRIA: for (int i = 0; i < 4; i++)
                          if (i < NSRC) rd_val[i*4 +: 3] = pri[i];
            SEL_PRIB: for (int i = 0; i < 4; i++)
                          if (i + 4 < NSRC) rd_val[i*4 +: 3] = pri[i+4];
            SEL_VEC:  rd_val = {12'd0, intrq != 3'd0, vector};
            default:  rd_val = '0;
        endcase
    end

    jt900h_intctl_arb u_arb (
        .pending (pend),
        .pri     (pri),
        .level   (win_level),
        .index   (win_index)
    );

    // Register file, pending latch and registered outputs, all gated by cen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2d_p2 <= '0;
            pend   <= '0;
            mode   <= '0;
            pri    <= '0;
            rdata  <= '0;
            intrq  <= '0;
            vector <= '0;
        end else if (cen) begin
            s2d_p2 <= s2_p1;
            pend   <= (pend & ~pend_clr) | pend_set;
            rdata  <= rd_val;
            intrq  <= win_level;
            vector <= win_index;
            if (sel == SEL_MODE && we[0])
                mode <= wdata[7:0] & SRC_MASK;
            for (int i = 0; i < 8; i++) begin
                if (i < NSRC && we[(i % 4) / 2] &&
                    sel == ((i < 4) ? SEL_PRIA : SEL_PRIB))
                    pri[i] <= wdata[(i % 4) * 4 +: 3];
            end
        end
    end

endmodule
